banked_stream_buffer: RTL
=========================

# banked_stream_buffer

Parametrised successor to the 8-bank SRAM/PE front end. It holds NUM_BANKS on-chip 1R1W SRAM banks and uses one state machine to stream a row range from all enabled banks in parallel into the PE array lanes under valid/ready. PE results are written back into a destination row range. Host load and readback are allowed only while idle.

## Interface
- DATA_WIDTH, 16, bits per lane/word
- NUM_BANKS, 8, banks = PE lanes (≥1)
- ADDR_WIDTH, 8, row address bits; depth 2^ADDR_WIDTH per bank
- BANK_SEL_W, $clog2(NUM_BANKS) (min 1), derived
---
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cfg_start  in  1  pulse; latches cfg_* and starts a job (ignored unless IDLE)
- cfg_src_base  in  ADDR_WIDTH  first source row
- cfg_dst_base  in  ADDR_WIDTH  first destination row
- cfg_len  in  ADDR_WIDTH+1  rows to stream (0..2^ADDR_WIDTH)
- cfg_bank_mask  in  NUM_BANKS  enabled lanes/banks
- host_we  in  1  host write strobe
- host_re  in  1  host read strobe
- host_bank  in  BANK_SEL_W  bank select
- host_addr  in  ADDR_WIDTH  row
- host_wdata  in  DATA_WIDTH  write data
- host_rdata  out  DATA_WIDTH  read data
- host_rvalid  out  1  read data valid
- pe_data  out  NUM_BANKS*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- pe_valid  out  1  pe_data valid
- pe_ready  in  1  PE accepts pe_data
- res_data  in  NUM_BANKS*DATA_WIDTH  PE results, same lane packing
- res_valid  in  1  result valid
- res_ready  out  1  block accepts result
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky host-access-while-busy flag

## Operation
- States: IDLE → STREAM → DRAIN → DONE → IDLE.
- IDLE: host ports active. cfg_start latches cfg_* and clears rd_cnt, wr_cnt and err. The next state is STREAM, or DONE if cfg_len = 0.
- STREAM: read-issue condition is (!pe_valid || pe_ready) && rd_cnt < len.
  - Each issued read fetches row (src_base + rd_cnt) mod 2^ADDR_WIDTH from every bank into the output register. Then rd_cnt++.
  - Lanes with mask bit 0 output zero.
  - When rd_cnt = len and the final word has been accepted, go to DRAIN.
- res_ready = 1 in STREAM and DRAIN while wr_cnt < len.
  - Each res_valid && res_ready handshake writes lane i to bank i at row (dst_base + wr_cnt) mod 2^ADDR_WIDTH, for masked-in lanes only. Then wr_cnt++.
- DRAIN: pe_valid = 0. When wr_cnt = len, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Host write in IDLE: host_wdata is written to host_bank/host_addr.
- Host read in IDLE: host_rdata is returned next cycle with host_rvalid = 1.
- host_we or host_re while busy: ignored, err ← 1, host_rvalid stays 0.
- host_bank ≥ NUM_BANKS: write dropped; read returns 0 with rvalid = 1.
- Same-cycle read and write to the same bank row: read returns old data.
- Source/destination overlap is permitted; ordering follows the rule above.

## Timing
- Reset values: pe_data 0, pe_valid 0, res_ready 0, host_rdata 0, host_rvalid 0, busy 0, done 0, err 0, state IDLE, counters 0. Memory contents are not cleared.
- Read latency is one cycle: issue at edge N, pe_valid/pe_data valid after edge N+1.
- Throughput: one row per cycle with pe_ready held high.
- pe_data is stable while pe_valid && !pe_ready.
- Minimum job time: first pe_valid one cycle after cfg_start; done two cycles after the last result handshake (DRAIN exits, DONE pulses).
- cfg_len = 0: done asserts in the cycle after cfg_start; no reads, no writes.
- Address counters wrap at 2^ADDR_WIDTH with no error.
- reset during a job: immediate return to IDLE, all outputs at reset values, and no further bank writes.

## Structure
- Shared package spadix_pkg:
  - state enum stream_state_t {IDLE, STREAM, DRAIN, DONE}
  - lane-slice helper localparams
- Sub-module sram_bank_1r1w:
  - parameters DATA_WIDTH, ADDR_WIDTH
  - registered read, one write port, read-before-write
  - instantiated NUM_BANKS times via generate
  - the read port is muxed between host and stream address by state

## Test plan
- Host-write bank 3 row 5 = 16'hBEEF, then host read → next cycle host_rdata = 16'hBEEF, rvalid = 1.
- Load rows 0..3 of all 8 banks with value bank*16 + row; start with src 0, len 4, mask 8'hFF, pe_ready = 1 → 4 consecutive pe_valid beats, lane i of beat r = i*16 + r, first beat one cycle after start.
- Same job with pe_ready toggling 1,0,0,1 → pe_data held stable during stalls, no beat lost or duplicated; loop results back with dst 8 → rows 8..11 match the source, done pulses once.
- mask 8'h0F, src 254, len 4 → lanes 4–7 read 0, source rows wrap 254,255,0,1; destination writes leave banks 4–7 untouched.
- cfg_len = 0 → done one cycle after start, busy high for exactly one cycle; host_we during busy → err = 1, memory unchanged.
- Assert reset mid-STREAM after 2 beats → all outputs 0 immediately; a later job completes normally.

Source files
------------

// File: rtl/spadix_pkg.sv
// Shared types and lane-slice helpers for the banked stream buffer.
// Lane i of a packed bus occupies bits [lane_lsb(i,w) +: w].
package spadix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_BANKS  = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sram_bank_1r1w.sv
// One SRAM bank: registered read, single write port, read-before-write.
// Contents are never cleared; only the read register matters after reset.
module sram_bank_1r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_stream_buffer.sv
// Streams a row range from all enabled banks into PE lanes and writes
// PE results back to a destination range; host access only when idle.
module banked_stream_buffer
  import spadix_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  NUM_BANKS  = DEF_NUM_BANKS,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_start,
  input  logic [ADDR_WIDTH-1:0]           cfg_src_base,
  input  logic [ADDR_WIDTH-1:0]           cfg_dst_base,
  input  logic [ADDR_WIDTH:0]             cfg_len,
  input  logic [NUM_BANKS-1:0]            cfg_bank_mask,
  input  logic                            host_we,
  input  logic                            host_re,
  input  logic [BANK_SEL_W-1:0]           host_bank,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic [DATA_WIDTH-1:0]           host_wdata,
  output logic [DATA_WIDTH-1:0]           host_rdata,
  output logic                            host_rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] pe_data,
  output logic                            pe_valid,
  input  logic                            pe_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] res_data,
  input  logic                            res_valid,
  output logic                            res_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  stream_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [NUM_BANKS-1:0]  mask_q, mask_d;
  logic                  pe_valid_q, pe_valid_d;
  logic                  err_q, err_d;
  logic                  rvalid_q, rvalid_d;
  logic [BANK_SEL_W-1:0] hbank_q, hbank_d;

  logic is_idle, start, start_rd, pe_free, issue, res_fire;
  logic host_rd, host_wr;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0] rdata [NUM_BANKS];

  assign is_idle  = (state_q == IDLE);
  assign start    = is_idle && cfg_start;
  assign start_rd = start && (cfg_len != '0);
  assign pe_free  = !pe_valid_q || pe_ready;
  assign issue    = (state_q == STREAM) && pe_free
                 && (rd_cnt_q < len_q);
  assign res_fire = res_valid && res_ready;
  // A starting job owns the read port in its first cycle.
  assign host_rd  = is_idle && host_re && !start_rd;
  assign host_wr  = is_idle && host_we && !reset;

  assign rd_addr = start_rd ? cfg_src_base :
                   (state_q == STREAM) ? src_q + rd_cnt_q[ADDR_WIDTH-1:0] :
                   host_addr;
  assign wr_addr = is_idle ? host_addr
                 : dst_q + wr_cnt_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = (cfg_len == '0) ? DONE : STREAM;
      STREAM: if (rd_cnt_q == len_q && pe_free) state_d = DRAIN;
      DRAIN:  if (wr_cnt_q == len_q) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    res_ready = (state_q == STREAM || state_q == DRAIN)
             && (wr_cnt_q < len_q);
  end

  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    mask_d     = mask_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    pe_valid_d = pe_valid_q;
    err_d      = err_q;
    rvalid_d   = host_rd;
    hbank_d    = host_bank;
    if (start) begin
      src_d    = cfg_src_base;
      dst_d    = cfg_dst_base;
      len_d    = cfg_len;
      mask_d   = cfg_bank_mask;
      rd_cnt_d = start_rd ? 1 : 0;
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      if (issue)    rd_cnt_d = rd_cnt_q + 1'b1;
      if (res_fire) wr_cnt_d = wr_cnt_q + 1'b1;
      if (busy && (host_we || host_re)) err_d = 1'b1;
    end
    if (start_rd || issue) pe_valid_d = 1'b1;
    else if (pe_ready)     pe_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      pe_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      hbank_q    <= '0;
    end else begin
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pe_valid_q <= pe_valid_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
      hbank_q    <= hbank_d;
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    localparam int LSB = lane_lsb(i, DATA_WIDTH);
    logic hsel, re, we;
    logic [DATA_WIDTH-1:0] wdata;

    assign hsel  = (host_bank == BANK_SEL_W'(i));
    assign re    = start_rd || issue || (host_rd && hsel);
    assign we    = (host_wr && hsel)
                || (res_fire && mask_q[i] && !reset);
    assign wdata = is_idle ? host_wdata
                 : res_data[LSB +: DATA_WIDTH];

    sram_bank_1r1w #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .re_i   (re),
      .raddr_i(rd_addr),
      .rdata_o(rdata[i]),
      .we_i   (we),
      .waddr_i(wr_addr),
      .wdata_i(wdata)
    );

    assign pe_data[LSB +: DATA_WIDTH] =
      (pe_valid_q && mask_q[i]) ? rdata[i] : '0;
  end

  // Unmapped bank selects fall through and read as zero.
  always_comb begin
    host_rdata = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (rvalid_q && hbank_q == BANK_SEL_W'(i))
        host_rdata = rdata[i];
  end

  assign host_rvalid = rvalid_q;
  assign pe_valid    = pe_valid_q;
  assign err         = err_q;

endmodule
